// File: rtl/input_cond_pkg.sv
// Shared types and constants for the push-button / slide-switch conditioner.
package input_cond_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } deb_state_t;

  localparam int   DEB_CYCLES_50MHZ_10MS = 500000;
  localparam logic BTN_IDLE              = 1'b1;
  localparam logic SW_IDLE               = 1'b0;

endpackage

// File: rtl/debounce_bit.sv
// One input bit: 2-flop synchroniser, stability counter FSM, clean level plus
// registered rise/fall pulses coincident with the level change.
module debounce_bit
  import input_cond_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = DEB_CYCLES_50MHZ_10MS,
  parameter logic IDLE_LEVEL      = 1'b0
) (
  input  logic clk,
  input  logic srst,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int             CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic          sync1_reg, sync2_reg;
  deb_state_t    state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          level_reg, level_next;
  logic          rise_reg, rise_next;
  logic          fall_reg, fall_next;

  always_ff @(posedge clk) begin
    if (srst) begin
      sync1_reg <= IDLE_LEVEL;
      sync2_reg <= IDLE_LEVEL;
      state_reg <= IDLE;
      cnt_reg   <= '0;
      level_reg <= IDLE_LEVEL;
      rise_reg  <= 1'b0;
      fall_reg  <= 1'b0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      level_reg <= level_next;
      rise_reg  <= rise_next;
      fall_reg  <= fall_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    level_next = level_reg;
    rise_next  = 1'b0;
    fall_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (sync2_reg != level_reg) begin
          state_next = COUNT;
          cnt_next   = CW'(1);
        end else begin
          cnt_next = '0;
        end
      end
      COUNT: begin
        if (sync2_reg == level_reg) begin
          // Input bounced back before the count completed: discard it.
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_MAX) begin
          level_next = ~level_reg;
          rise_next  = ~level_reg;
          fall_next  = level_reg;
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign level = level_reg;
  assign rise  = rise_reg;
  assign fall  = fall_reg;

endmodule

// File: rtl/input_conditioner.sv
// Debounces the DE10-Lite keys and switches into clean levels for the PIOs,
// plus per-bit press/release/change pulses and a delayed any-event flag.
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEB_CYCLES_50MHZ_10MS,
  parameter int BTN_W           = 4,
  parameter int SW_W            = 10
) (
  input  logic             clk_clk,
  input  logic             reset_reset,
  input  logic [BTN_W-1:0] btn_raw_n,
  input  logic [SW_W-1:0]  sw_raw,
  output logic [BTN_W-1:0] btn_level,
  output logic [SW_W-1:0]  sw_level,
  output logic [BTN_W-1:0] btn_press,
  output logic [BTN_W-1:0] btn_release,
  output logic [SW_W-1:0]  sw_change,
  output logic             any_event
);

  logic [SW_W-1:0] sw_rise;
  logic [SW_W-1:0] sw_fall;
  logic            any_event_reg;

  // Keys are active-low, so a falling debounced level is a press.
  generate
    for (genvar gi = 0; gi < BTN_W; gi++) begin : g_btn
      debounce_bit #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .IDLE_LEVEL     (BTN_IDLE)
      ) u_deb (
        .clk  (clk_clk),
        .srst (reset_reset),
        .raw  (btn_raw_n[gi]),
        .level(btn_level[gi]),
        .rise (btn_release[gi]),
        .fall (btn_press[gi])
      );
    end

    for (genvar gi = 0; gi < SW_W; gi++) begin : g_sw
      debounce_bit #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .IDLE_LEVEL     (SW_IDLE)
      ) u_deb (
        .clk  (clk_clk),
        .srst (reset_reset),
        .raw  (sw_raw[gi]),
        .level(sw_level[gi]),
        .rise (sw_rise[gi]),
        .fall (sw_fall[gi])
      );
    end
  endgenerate

  assign sw_change = sw_rise | sw_fall;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      any_event_reg <= 1'b0;
    end else begin
      any_event_reg <= |{btn_press, btn_release, sw_change};
    end
  end

  assign any_event = any_event_reg;

endmodule
